// File: rtl/comp_scan_ctrl.sv
// comp_scan_ctrl: streams a burst of signed samples and tracks the running
// maximum and minimum together with the index of their first occurrence.
module comp_scan_ctrl #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned COUNTW    = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [COUNTW-1:0]    Len,
  input  logic                 InValid,
  input  logic [DATAWIDTH-1:0] InData,
  output logic                 InReady,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err,
  output logic [DATAWIDTH-1:0] Max,
  output logic [DATAWIDTH-1:0] Min,
  output logic [COUNTW-1:0]    MaxIdx,
  output logic [COUNTW-1:0]    MinIdx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [COUNTW-1:0]            len_q, len_d;
  logic [COUNTW-1:0]            count_q, count_d;
  logic signed [DATAWIDTH-1:0]  max_q, max_d;
  logic signed [DATAWIDTH-1:0]  min_q, min_d;
  logic [COUNTW-1:0]            max_idx_q, max_idx_d;
  logic [COUNTW-1:0]            min_idx_q, min_idx_d;
  logic                         err_q, err_d;
  logic                         in_ready_q, in_ready_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic signed [DATAWIDTH-1:0]  in_s;
  logic                         accept;

  assign in_s   = $signed(InData);
  assign accept = InValid & in_ready_q;

  // Next-state, datapath updates and registered status outputs.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    err_d     = err_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          len_d   = Len;
          err_d   = 1'b0;
          count_d = '0;
          if (Len == '0) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_FIRST;
          end
        end
      end
      ST_FIRST: begin
        if (accept) begin
          max_d     = in_s;
          min_d     = in_s;
          max_idx_d = '0;
          min_idx_d = '0;
          count_d   = COUNTW'(1);
          state_d   = (len_q == COUNTW'(1)) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (accept) begin
          // strict compares keep the earliest index on ties
          if (in_s > max_q) begin
            max_d     = in_s;
            max_idx_d = count_q;
          end
          if (in_s < min_q) begin
            min_d     = in_s;
            min_idx_d = count_q;
          end
          count_d = count_q + COUNTW'(1);
          if (count_q == len_q - COUNTW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // status flops follow the state being entered so they line up with it
    in_ready_d = (state_d == ST_FIRST) || (state_d == ST_SCAN);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State and result registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      max_q      <= '0;
      min_q      <= '0;
      max_idx_q  <= '0;
      min_idx_q  <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      max_q      <= max_d;
      min_q      <= min_d;
      max_idx_q  <= max_idx_d;
      min_idx_q  <= min_idx_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign InReady = in_ready_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign Max     = max_q;
  assign Min     = min_q;
  assign MaxIdx  = max_idx_q;
  assign MinIdx  = min_idx_q;

endmodule

// File: tb/tb_comp_scan_ctrl.sv
// Scoreboard bench for comp_scan_ctrl: expected results are queued when a
// burst is issued and checked when the DUT pulses Done.
module tb_comp_scan_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [CW-1:0] Len;
  logic          InValid;
  logic [DW-1:0] InData;
  logic          InReady, Busy, Done, Err;
  logic [DW-1:0] Max, Min;
  logic [CW-1:0] MaxIdx, MinIdx;

  comp_scan_ctrl #(.DATAWIDTH(DW), .COUNTW(CW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Len(Len),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .Busy(Busy), .Done(Done), .Err(Err),
    .Max(Max), .Min(Min), .MaxIdx(MaxIdx), .MinIdx(MinIdx)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] mx;
    logic [DW-1:0] mn;
    logic [CW-1:0] mxi;
    logic [CW-1:0] mni;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          prev;
  logic [DW-1:0] smp[16];
  int            stl[16];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            done_cnt = 0;
  int            n_bursts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // reference model of one burst, computed from the samples being driven
  task automatic push_expected(input int len);
    exp_t e;
    logic signed [DW-1:0] v;
    if (len == 0) begin
      e = prev;
      e.err = 1'b1;
    end else begin
      e.mx = smp[0]; e.mn = smp[0]; e.mxi = '0; e.mni = '0; e.err = 1'b0;
      for (int i = 1; i < len; i++) begin
        v = $signed(smp[i]);
        if (v > $signed(e.mx)) begin e.mx = smp[i]; e.mxi = CW'(i); end
        if (v < $signed(e.mn)) begin e.mn = smp[i]; e.mni = CW'(i); end
      end
    end
    prev = e;
    exp_q.push_back(e);
    n_bursts++;
  endtask

  task automatic run_burst(input int len, input int inject_at);
    push_expected(len);
    Start = 1'b1;
    Len   = CW'(len);
    tick();
    Start = 1'b0;
    Len   = '0;
    check("busy_after_start", 32'(Busy), 1);
    if (len == 0) begin
      check("done_len0", 32'(Done), 1);
      check("err_len0", 32'(Err), 1);
      check("inready_len0", 32'(InReady), 0);
    end else begin
      for (int i = 0; i < len; i++) begin
        for (int s = 0; s < stl[i]; s++) begin
          InValid = 1'b0;
          tick();
          check("stall_no_done", 32'(Done), 0);
        end
        InValid = 1'b1;
        InData  = smp[i];
        if (i == inject_at) begin
          Start = 1'b1;
          Len   = CW'(9);
        end
        check("inready_scan", 32'(InReady), 1);
        tick();
        InValid = 1'b0;
        Start   = 1'b0;
        Len     = '0;
        if (i < len - 1) check("no_early_done", 32'(Done), 0);
      end
      check("done_latency", 32'(Done), 1);
      check("inready_done", 32'(InReady), 0);
      check("busy_done", 32'(Busy), 1);
    end
    tick();
    check("done_one_cycle", 32'(Done), 0);
    check("idle_busy", 32'(Busy), 0);
    check("idle_inready", 32'(InReady), 0);
  endtask

  // Scoreboard consumer: compare results whenever Done is seen.
  always @(negedge Clk) begin
    if (Rst && Done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("max", 32'(Max), 32'(e.mx));
        check("min", 32'(Min), 32'(e.mn));
        check("max_idx", 32'(MaxIdx), 32'(e.mxi));
        check("min_idx", 32'(MinIdx), 32'(e.mni));
        check("err", 32'(Err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int saved_done;
    Rst = 1'b0; Start = 1'b0; Len = '0; InValid = 1'b0; InData = '0;
    prev = '{mx: '0, mn: '0, mxi: '0, mni: '0, err: 1'b0};
    for (int i = 0; i < 16; i++) begin smp[i] = '0; stl[i] = 0; end
    #12;
    check("rst_max", 32'(Max), 0);
    check("rst_min", 32'(Min), 0);
    check("rst_idx", 32'({MaxIdx, MinIdx}), 0);
    check("rst_flags", 32'({InReady, Busy, Done, Err}), 0);
    @(posedge Clk); #1 Rst = 1'b1;
    tick();

    // reset in the middle of a burst: results return to zero, no Done
    saved_done = done_cnt;
    Start = 1'b1; Len = CW'(5); tick(); Start = 1'b0;
    InValid = 1'b1; InData = 8'd20; tick();
    InData = 8'd30; tick();
    check("pre_rst_max", 32'(Max), 32'd30);
    InData = 8'd40;
    #2 Rst = 1'b0;
    #1;
    check("arst_max", 32'(Max), 0);
    check("arst_flags", 32'({InReady, Busy, Done, Err}), 0);
    InValid = 1'b0;
    tick();
    Rst = 1'b1;
    tick(); tick(); tick();
    check("abort_no_done", 32'(done_cnt), 32'(saved_done));
    check("abort_idle", 32'(Busy), 0);

    // normal burst after reset
    smp[0] = 8'd1; smp[1] = 8'd9; smp[2] = 8'hFE;
    run_burst(3, -1);

    // basic burst
    smp[0] = 8'd5; smp[1] = 8'hFD; smp[2] = 8'd12; smp[3] = 8'd0;
    run_burst(4, -1);

    // signed extremes with ties
    smp[0] = 8'h80; smp[1] = 8'h7F; smp[2] = 8'h7F; smp[3] = 8'h80; smp[4] = 8'h00;
    run_burst(5, -1);

    // stalls: InValid 1,0,0,1,0,1
    smp[0] = 8'd3; smp[1] = 8'hF0; smp[2] = 8'd100;
    stl[0] = 0; stl[1] = 2; stl[2] = 1;
    run_burst(3, -1);
    for (int i = 0; i < 16; i++) stl[i] = 0;

    // Len=0 keeps previous results and flags Err, which persists in IDLE
    run_burst(0, -1);
    check("err_sticky", 32'(Err), 1);

    // Len=1
    smp[0] = 8'hF9;
    run_burst(1, -1);

    // Start with Len=9 during a busy Len=3 burst is ignored
    smp[0] = 8'd7; smp[1] = 8'd2; smp[2] = 8'd7;
    run_burst(3, 1);
    tick(); tick();
    check("no_second_burst", 32'(Busy), 0);

    // longer pseudo-random burst with occasional stalls
    for (int i = 0; i < 12; i++) begin
      smp[i] = DW'($urandom_range(0, 255));
      stl[i] = (($urandom_range(0, 3)) == 0) ? 1 : 0;
    end
    run_burst(12, -1);

    tick();
    check("done_count", 32'(done_cnt), 32'(n_bursts));
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
